// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and helpers for the FU writeback arbiter.
package fu_wb_arbiter_pkg;

    localparam int NR_WB_PORTS   = 2;
    localparam int TRANS_ID_BITS = 3;
    localparam int WB_DATA_W     = 64;

    // One buffered FU result as it travels to the scoreboard.
    typedef struct packed {
        logic [WB_DATA_W-1:0]     result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     ex_valid;
        logic [63:0]              ex_cause;
    } wb_entry_t;

    // Increment an index that wraps at n, which need not be a power of 2.
    function automatic int rr_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// Bundle of FU-side result channels and scoreboard-side writeback ports.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. A producer that raised valid keeps valid and its payload stable until
// the transfer happens. ch_ready_o comes from registered state only; wb_valid_o
// never waits on wb_ready_i.
interface fu_wb_arbiter_if #(
    parameter int NR_CH  = 4,
    parameter int NR_WB  = 2,
    parameter int DATA_W = 64,
    parameter int TID_W  = 3
);
    localparam int IDX_W = $clog2(NR_CH);

    logic [NR_CH-1:0]        ch_valid_i;
    logic [NR_CH-1:0]        ch_ready_o;
    logic [NR_CH*DATA_W-1:0] ch_result_i;
    logic [NR_CH*TID_W-1:0]  ch_trans_id_i;
    logic [NR_CH-1:0]        ch_ex_valid_i;
    logic [NR_CH*64-1:0]     ch_ex_cause_i;

    logic [NR_WB-1:0]        wb_valid_o;
    logic [NR_WB-1:0]        wb_ready_i;
    logic [NR_WB*DATA_W-1:0] wb_result_o;
    logic [NR_WB*TID_W-1:0]  wb_trans_id_o;
    logic [NR_WB-1:0]        wb_ex_valid_o;
    logic [NR_WB*64-1:0]     wb_ex_cause_o;
    logic [NR_WB*IDX_W-1:0]  wb_ch_o;

    // Arbiter side.
    modport slave (
        input  ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_valid_i, ch_ex_cause_i,
        input  wb_ready_i,
        output ch_ready_o,
        output wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o, wb_ch_o
    );

    // FU and scoreboard side.
    modport master (
        output ch_valid_i, ch_result_i, ch_trans_id_i, ch_ex_valid_i, ch_ex_cause_i,
        output wb_ready_i,
        input  ch_ready_o,
        input  wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o, wb_ex_cause_o, wb_ch_o
    );

endinterface

// File: rtl/fu_wb_arbiter_wb_rr_select.sv
// Round-robin selector: starting at i_ptr, hands the first NR_WB requesting
// channels to ports 0..NR_WB-1 in scan order, at most one port per channel.
module wb_rr_select #(
    parameter int NR_CH = 4,
    parameter int NR_WB = 2,
    localparam int IDX_W = $clog2(NR_CH)
) (
    input  logic [NR_CH-1:0]                  i_req,
    input  logic [IDX_W-1:0]                  i_ptr,
    output logic [NR_WB-1:0][NR_CH-1:0]       o_grant,
    output logic [NR_WB-1:0]                  o_valid,
    output logic [NR_WB-1:0][IDX_W-1:0]       o_idx
);

    logic [NR_CH-1:0] w_taken;
    int               w_c;

    // Scan channels from the pointer once per port, skipping channels already given a port.
    always_comb begin
        o_grant = '0;
        o_valid = '0;
        o_idx   = '0;
        w_taken = '0;
        w_c     = 0;
        for (int k = 0; k < NR_WB; k++) begin
            for (int i = 0; i < NR_CH; i++) begin
                w_c = (int'(i_ptr) + i) % NR_CH;
                if (!o_valid[k] && i_req[w_c] && !w_taken[w_c]) begin
                    o_valid[k]      = 1'b1;
                    o_grant[k][w_c] = 1'b1;
                    o_idx[k]        = IDX_W'(w_c);
                    w_taken[w_c]    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback stage: per-FU result FIFOs arbitrated round-robin onto NR_WB
// scoreboard writeback ports, with backpressure and flush.
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
#(
    parameter int NR_CH  = 4,
    parameter int NR_WB  = NR_WB_PORTS,
    parameter int DEPTH  = 2,
    parameter int DATA_W = WB_DATA_W,
    parameter int TID_W  = TRANS_ID_BITS
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    fu_wb_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NR_CH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [IDX_W-1:0]                r_rr_ptr;
    logic [NR_CH-1:0]                r_refused;
    logic [NR_CH-1:0]                w_ready;
    logic [NR_CH-1:0]                w_req;
    logic [NR_CH-1:0]                w_enq;
    logic [NR_CH-1:0]                w_deq;
    logic [NR_WB-1:0][NR_CH-1:0]     w_grant;
    logic [NR_WB-1:0]                w_gnt_valid;
    logic [NR_WB-1:0][IDX_W-1:0]     w_gnt_idx;
    logic                            w_acc_any;
    logic [IDX_W-1:0]                w_last_acc;

    logic [NR_CH-1:0][DATA_W-1:0]    w_head_result;
    logic [NR_CH-1:0][TID_W-1:0]     w_head_tid;
    logic [NR_CH-1:0]                w_head_exv;
    logic [NR_CH-1:0][63:0]          w_head_cause;

    assign bus.ch_ready_o = w_ready;

    for (genvar c = 0; c < NR_CH; c++) begin : g_ch
        logic [DATA_W-1:0] r_result [DEPTH];
        logic [TID_W-1:0]  r_tid    [DEPTH];
        logic              r_exv    [DEPTH];
        logic [63:0]       r_cause  [DEPTH];
        logic [PTR_W-1:0]  r_wptr;
        logic [PTR_W-1:0]  r_rptr;
        logic [CNT_W-1:0]  r_cnt;

        // A full channel stays not-ready even when it drains this cycle.
        assign w_ready[c] = (r_cnt != CNT_W'(DEPTH));
        assign w_enq[c]   = bus.ch_valid_i[c] & w_ready[c] & ~flush_i;
        assign w_req[c]   = (r_cnt != '0);

        assign w_head_result[c] = r_result[r_rptr];
        assign w_head_tid[c]    = r_tid[r_rptr];
        assign w_head_exv[c]    = r_exv[r_rptr];
        assign w_head_cause[c]  = r_cause[r_rptr];

        // Pointer and occupancy bookkeeping; flush empties the channel like reset.
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_cnt  <= '0;
            end else begin
                if (w_enq[c])
                    r_wptr <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
                if (w_deq[c])
                    r_rptr <= (r_rptr == PTR_W'(DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
                if (w_enq[c] && !w_deq[c])
                    r_cnt <= r_cnt + CNT_W'(1);
                else if (!w_enq[c] && w_deq[c])
                    r_cnt <= r_cnt - CNT_W'(1);
            end
        end

        // Entry storage; contents are only meaningful below the occupancy count.
        always_ff @(posedge clk_i) begin
            if (w_enq[c]) begin
                r_result[r_wptr] <= bus.ch_result_i[c*DATA_W +: DATA_W];
                r_tid[r_wptr]    <= bus.ch_trans_id_i[c*TID_W +: TID_W];
                r_exv[r_wptr]    <= bus.ch_ex_valid_i[c];
                r_cause[r_wptr]  <= bus.ch_ex_cause_i[c*64 +: 64];
            end
        end
    end

    wb_rr_select #(
        .NR_CH (NR_CH),
        .NR_WB (NR_WB)
    ) u_sel (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

    // Accepted grants pop their channel; the last accepted port is the furthest in scan order.
    always_comb begin
        w_deq      = '0;
        w_acc_any  = 1'b0;
        w_last_acc = '0;
        for (int k = 0; k < NR_WB; k++) begin
            if (w_gnt_valid[k] && bus.wb_ready_i[k] && !flush_i) begin
                w_deq      = w_deq | w_grant[k];
                w_acc_any  = 1'b1;
                w_last_acc = w_gnt_idx[k];
            end
        end
    end

    // Drive granted heads onto the ports; ungranted ports and the flush cycle read as zero.
    always_comb begin
        bus.wb_valid_o    = '0;
        bus.wb_result_o   = '0;
        bus.wb_trans_id_o = '0;
        bus.wb_ex_valid_o = '0;
        bus.wb_ex_cause_o = '0;
        bus.wb_ch_o       = '0;
        for (int k = 0; k < NR_WB; k++) begin
            if (w_gnt_valid[k] && !flush_i) begin
                bus.wb_valid_o[k]                    = 1'b1;
                bus.wb_result_o[k*DATA_W +: DATA_W]  = w_head_result[w_gnt_idx[k]];
                bus.wb_trans_id_o[k*TID_W +: TID_W]  = w_head_tid[w_gnt_idx[k]];
                bus.wb_ex_valid_o[k]                 = w_head_exv[w_gnt_idx[k]];
                bus.wb_ex_cause_o[k*64 +: 64]        = w_head_cause[w_gnt_idx[k]];
                bus.wb_ch_o[k*IDX_W +: IDX_W]        = w_gnt_idx[k];
            end
        end
    end

    // Round-robin pointer moves just past the furthest accepted channel.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i)
            r_rr_ptr <= '0;
        else if (w_acc_any)
            r_rr_ptr <= IDX_W'(rr_wrap_inc(int'(w_last_acc), NR_CH));
    end

    // Remember pushes that were refused so a withdrawn result can be caught next cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_refused <= '0;
        else
            r_refused <= bus.ch_valid_i & ~w_ready & {NR_CH{~flush_i}};
    end

    // An FU whose result was refused must keep offering it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i)
            assert ((r_refused & ~bus.ch_valid_i) == '0);
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Directed bench for fu_wb_arbiter: single push, contention, backpressure,
// fairness (single-port instance), flush and reset priority.
module tb_fu_wb_arbiter;
    import fu_wb_arbiter_pkg::*;

    localparam int EXP_W = 2 + $bits(wb_entry_t);

    logic clk;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] sb_e;
    int               g[6];
    int               pos;
    int               n;
    bit               dbl;

    fu_wb_arbiter_if #(.NR_CH(4), .NR_WB(2), .DATA_W(64), .TID_W(3)) bus ();
    fu_wb_arbiter_if #(.NR_CH(4), .NR_WB(1), .DATA_W(64), .TID_W(3)) bus1 ();

    fu_wb_arbiter #(.NR_CH(4), .NR_WB(2), .DEPTH(2), .DATA_W(64), .TID_W(3)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    fu_wb_arbiter #(.NR_CH(4), .NR_WB(1), .DEPTH(2), .DATA_W(64), .TID_W(3)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (1'b0),
        .bus     (bus1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ch(input int c, input logic [63:0] res, input logic [2:0] tid,
                           input logic exv, input logic [63:0] cause, input bit expect_wb);
        wb_entry_t e;
        bus.ch_valid_i[c]            = 1'b1;
        bus.ch_result_i[c*64 +: 64]  = res;
        bus.ch_trans_id_i[c*3 +: 3]  = tid;
        bus.ch_ex_valid_i[c]         = exv;
        bus.ch_ex_cause_i[c*64 +: 64] = cause;
        if (expect_wb) begin
            e = '{result: res, trans_id: tid, ex_valid: exv, ex_cause: cause};
            exp_q.push_back({2'(c), e});
        end
    endtask

    task automatic push1(input int c, input logic [63:0] res, input logic [2:0] tid);
        bus1.ch_valid_i[c]           = 1'b1;
        bus1.ch_result_i[c*64 +: 64] = res;
        bus1.ch_trans_id_i[c*3 +: 3] = tid;
    endtask

    task automatic clr_all();
        bus.ch_valid_i    = '0;
        bus.ch_result_i   = '0;
        bus.ch_trans_id_i = '0;
        bus.ch_ex_valid_i = '0;
        bus.ch_ex_cause_i = '0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    // scoreboard: every accepted writeback must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (bus.wb_valid_o[k] && bus.wb_ready_i[k]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL sb_unexpected port=%0d observed_tid=%0d observed_ch=%0d expected=none",
                               k, bus.wb_trans_id_o[k*3 +: 3], bus.wb_ch_o[k*2 +: 2]);
                    end else begin
                        sb_e = exp_q.pop_front();
                        check("sb_entry",
                              {bus.wb_ch_o[k*2 +: 2], bus.wb_result_o[k*64 +: 64], bus.wb_trans_id_o[k*3 +: 3],
                               bus.wb_ex_valid_o[k], bus.wb_ex_cause_o[k*64 +: 64]},
                              sb_e);
                    end
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clr_all();
        bus.wb_ready_i     = '0;
        bus1.ch_valid_i    = '0;
        bus1.ch_result_i   = '0;
        bus1.ch_trans_id_i = '0;
        bus1.ch_ex_valid_i = '0;
        bus1.ch_ex_cause_i = '0;
        bus1.wb_ready_i    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_ready", bus.ch_ready_o, 4'hF);
        check("rst_valid", bus.wb_valid_o, 2'b00);
        check("rst_result", bus.wb_result_o, '0);
        check("rst_ch", bus.wb_ch_o, 4'h0);

        // single push on ch2
        tick();
        bus.wb_ready_i = 2'b11;
        push_ch(2, 64'hDEAD, 3'd5, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        check("single_nobypass", bus.wb_valid_o, 2'b00);
        tick();
        clr_all();
        @(negedge clk);
        check("single_valid", bus.wb_valid_o, 2'b01);
        check("single_result", bus.wb_result_o[63:0], 64'hDEAD);
        check("single_tid", bus.wb_trans_id_o[2:0], 3'd5);
        check("single_ch", bus.wb_ch_o[1:0], 2'd2);
        check("single_port1_silent", {bus.wb_result_o[127:64], bus.wb_trans_id_o[5:3], bus.wb_ch_o[3:2]}, '0);

        // idle flush puts the RR pointer back at 0
        tick();
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_valid", bus.wb_valid_o, 2'b00);
        tick();
        flush = 1'b0;

        // contention: all four channels push together
        for (int c = 0; c < 4; c++)
            push_ch(c, 64'h100 + 64'(c), 3'(c), (c == 2), (c == 2) ? 64'hC2 : 64'h0, 1'b1);
        @(negedge clk);
        check("cont_nobypass", bus.wb_valid_o, 2'b00);
        tick();
        clr_all();
        @(negedge clk);
        check("cont_c1_valid", bus.wb_valid_o, 2'b11);
        check("cont_c1_ch", bus.wb_ch_o, {2'd1, 2'd0});
        tick();
        @(negedge clk);
        check("cont_c2_valid", bus.wb_valid_o, 2'b11);
        check("cont_c2_ch", bus.wb_ch_o, {2'd3, 2'd2});
        check("cont_c2_exv", bus.wb_ex_valid_o, 2'b01);
        tick();
        @(negedge clk);
        check("cont_empty", bus.wb_valid_o, 2'b00);
        tick();
        push_ch(3, 64'h333, 3'd3, 1'b0, 64'h0, 1'b0);
        push_ch(0, 64'h300, 3'd0, 1'b0, 64'h0, 1'b0);
        exp_q.push_back({2'd0, 64'h300, 3'd0, 1'b0, 64'h0});
        exp_q.push_back({2'd3, 64'h333, 3'd3, 1'b0, 64'h0});
        tick();
        clr_all();
        @(negedge clk);
        check("cont_ptr0_ch", bus.wb_ch_o, {2'd3, 2'd0});
        tick();
        wait_drain("cont_drain");

        // backpressure: scoreboard stalls five cycles while ch0 pushes three results
        bus.wb_ready_i = 2'b00;
        push_ch(0, 64'hA0, 3'd0, 1'b0, 64'h0, 1'b1);
        check("bp_ready_0", bus.ch_ready_o[0], 1'b1);
        tick();
        push_ch(0, 64'hA1, 3'd1, 1'b0, 64'h0, 1'b1);
        check("bp_ready_1", bus.ch_ready_o[0], 1'b1);
        @(negedge clk);
        check("bp_hold_head", {bus.wb_valid_o, bus.wb_trans_id_o[2:0]}, {2'b01, 3'd0});
        tick();
        push_ch(0, 64'hA2, 3'd2, 1'b0, 64'h0, 1'b1);
        check("bp_full", bus.ch_ready_o[0], 1'b0);
        tick();
        check("bp_full_hold", bus.ch_ready_o[0], 1'b0);
        @(negedge clk);
        check("bp_head_still", {bus.wb_valid_o, bus.wb_trans_id_o[2:0]}, {2'b01, 3'd0});
        repeat (2) tick();
        bus.wb_ready_i = 2'b11;
        check("bp_full_while_deq", bus.ch_ready_o[0], 1'b0);
        tick();
        check("bp_ready_after_deq", bus.ch_ready_o[0], 1'b1);
        tick();
        clr_all();
        wait_drain("bp_drain");

        // fairness on the single-port instance
        push1(0, 64'hF0, 3'd0);
        push1(3, 64'hF3, 3'd3);
        tick();
        bus1.ch_valid_i[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g[i] = bus1.wb_valid_o[0] ? int'(bus1.wb_ch_o) : 9;
            tick();
        end
        pos = 99;
        for (int i = 0; i < 6; i++) if (g[i] == 3 && pos == 99) pos = i;
        dbl = 1'b0;
        for (int i = 0; i < 5; i++) if (i + 1 <= pos && g[i] == 0 && g[i+1] == 0) dbl = 1'b1;
        check("fair_first", g[0], 0);
        check("fair_second", g[1], 3);
        check("fair_latency", (pos < 4), 1'b1);
        check("fair_no_double", dbl, 1'b0);
        n = 0;
        while (!bus1.ch_ready_o[0] && n < 8) begin
            tick();
            n++;
        end
        check("fair_stop_ready", bus1.ch_ready_o[0], 1'b1);
        tick();
        bus1.ch_valid_i = '0;

        // flush with every channel holding two stale entries
        bus.wb_ready_i = 2'b00;
        for (int c = 0; c < 4; c++) push_ch(c, 64'hF0 + 64'(c), 3'd6, 1'b0, 64'h0, 1'b0);
        check("fl_ready_empty", bus.ch_ready_o, 4'hF);
        tick();
        for (int c = 0; c < 4; c++) push_ch(c, 64'hE0 + 64'(c), 3'd7, 1'b0, 64'h0, 1'b0);
        check("fl_ready_one", bus.ch_ready_o, 4'hF);
        tick();
        clr_all();
        push_ch(1, 64'hBAD, 3'd4, 1'b0, 64'h0, 1'b0);
        flush = 1'b1;
        bus.wb_ready_i = 2'b11;
        check("fl_full", bus.ch_ready_o, 4'h0);
        @(negedge clk);
        check("fl_valid_forced", bus.wb_valid_o, 2'b00);
        check("fl_data_zero", bus.wb_result_o, '0);
        tick();
        flush = 1'b0;
        clr_all();
        check("fl_ready_after", bus.ch_ready_o, 4'hF);
        @(negedge clk);
        check("fl_valid_after", bus.wb_valid_o, 2'b00);
        repeat (3) tick();

        // reset wins over flush mid-stream
        push_ch(2, 64'h2222, 3'd1, 1'b0, 64'h0, 1'b1);
        tick();
        clr_all();
        tick();
        bus.wb_ready_i = 2'b00;
        push_ch(0, 64'h5550, 3'd2, 1'b0, 64'h0, 1'b0);
        push_ch(1, 64'h5551, 3'd3, 1'b1, 64'h77, 1'b0);
        tick();
        clr_all();
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("rp_valid", bus.wb_valid_o, 2'b00);
        check("rp_ready", bus.ch_ready_o, 4'hF);
        check("rp_data", {bus.wb_result_o, bus.wb_trans_id_o, bus.wb_ch_o}, '0);
        check("rp_ex", {bus.wb_ex_valid_o, bus.wb_ex_cause_o}, '0);
        tick();
        bus.wb_ready_i = 2'b11;
        push_ch(1, 64'h1111, 3'd5, 1'b0, 64'h0, 1'b1);
        push_ch(3, 64'h3333, 3'd6, 1'b0, 64'h0, 1'b1);
        tick();
        clr_all();
        @(negedge clk);
        check("rp_ptr0_ch", bus.wb_ch_o, {2'd3, 2'd1});
        tick();
        wait_drain("rp_drain");

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Parametrised writeback stage for execute-stage functional units.
- Replaces the single fixed-priority result mux and single write port with NR_CH buffered result channels arbitrated round-robin onto NR_WB scoreboard writeback ports.
- Adds per-channel buffering, backpressure toward functional units, fairness, and flush; sits between the FUs (ALU, CSR buffer, mult, FPU) and the scoreboard.

Parameters:
- NR_CH, 4, number of FU result channels (2..8).
- NR_WB, 2, number of writeback ports (1..NR_CH).
- DEPTH, 2, entries per channel buffer (power of 2, >=1).
- DATA_W, 64, result width.
- TID_W, 3, transaction ID width (equals TRANS_ID_BITS).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all buffered results.
- ch_valid_i  in  NR_CH  per-channel result valid.
- ch_ready_o  out  NR_CH  per-channel buffer can accept.
- ch_result_i  in  NR_CH*DATA_W  channel results, channel c at bits [c*DATA_W +: DATA_W].
- ch_trans_id_i  in  NR_CH*TID_W  scoreboard IDs.
- ch_ex_valid_i  in  NR_CH  exception flag.
- ch_ex_cause_i  in  NR_CH*64  exception cause.
- wb_valid_o  out  NR_WB  writeback port valid.
- wb_ready_i  in  NR_WB  scoreboard accepts port.
- wb_result_o  out  NR_WB*DATA_W  writeback data.
- wb_trans_id_o  out  NR_WB*TID_W  writeback ID.
- wb_ex_valid_o  out  NR_WB  exception flag.
- wb_ex_cause_o  out  NR_WB*64  exception cause.
- wb_ch_o  out  NR_WB*$clog2(NR_CH)  source channel (debug/perf).

Behaviour:
- One clock; reset is synchronous, active-high on rst_i. On reset: all buffers empty, RR pointer = 0, ch_ready_o = all 1 from the next cycle, wb_valid_o = 0, all wb data fields = 0.
- Each channel has a DEPTH-entry FIFO of {result, trans_id, ex_valid, ex_cause}, with read/write pointers and a count of $clog2(DEPTH)+1 bits.
- Enqueue when ch_valid_i & ch_ready_o.
- ch_ready_o[c] = (count[c] != DEPTH). It depends on registered state only, with no combinational path from wb_ready_i or ch_valid_i.
- Full channel: not ready, even if it dequeues in the same cycle. The FU must hold its result; a dropped valid is a protocol violation, flagged by an assertion.
- No bypass: a result enqueued in cycle t is visible on wb at t+1 at the earliest.
- Arbitration (combinational from FIFO heads):
  - Scan channels starting at the RR pointer, wrapping modulo NR_CH.
  - The first non-empty channel goes to port 0, the next to port 1, up to NR_WB grants.
  - A channel receives at most one port per cycle.
  - Unused ports: valid 0, data 0 (data silencing).
- Dequeue channel c when its granted port k has wb_ready_i[k]=1.
- An unaccepted grant holds its head entry. That entry is re-arbitrated next cycle and may move to a different port.
- Simultaneous enqueue and dequeue on a non-full channel: count unchanged, both pointers advance.
- RR pointer update:
  - If at least one grant is accepted, the pointer moves to (highest-scan-order accepted channel + 1) mod NR_CH.
  - Otherwise it is unchanged.
  - Guarantee: any non-empty channel is granted within ceil(NR_CH/NR_WB) cycles of all-ready scoreboard.
- Pointer wrap: FIFO pointers wrap at DEPTH; RR pointer wraps at NR_CH (non-power-of-2 NR_CH must wrap explicitly).
- flush_i:
  - Next cycle: all counts 0, pointers 0, RR pointer 0.
  - Inputs presented during the flush cycle are discarded.
  - wb_valid_o is forced 0 in the flush cycle itself.
- rst_i has priority over flush_i. Reset mid-transfer drops all entries without writeback.
- Exceptions pass through unchanged; ex_valid does not affect arbitration priority.

Decomposition:
- ariane_pkg gains a wb_entry_t struct {result, trans_id, ex_valid, ex_cause}.
- ariane_pkg gains the constant NR_WB_PORTS.
- One sub-module, wb_rr_select: rotate-and-priority-encode NR_CH requests into NR_WB one-hot grants given the RR pointer. It is purely combinational and instantiated once.
- The FIFOs are a generate loop inside fu_wb_arbiter.

Test Plan:
- Reset, then single push: ch2 pushes result 0xDEAD, tid 5 at cycle 1 → wb_valid_o[0]=1 at cycle 2 with 0xDEAD, tid 5, wb_ch=2; port 1 invalid with data 0.
- Contention: NR_CH=4, NR_WB=2, all channels push once in the same cycle, wb_ready all 1 → cycle+1 grants ch0/ch1, cycle+2 grants ch2/ch3, pointer returns to 0.
- Backpressure: wb_ready_i=0 for 5 cycles while ch0 pushes 3 results, DEPTH=2 → ch_ready_o[0]=0 after 2 enqueues, third held by FU; release → IDs emerge in order 0,1,2.
- Fairness: ch0 pushes every cycle while ch3 holds one entry, NR_WB=1 → ch3 is granted within 4 cycles and ch0 is never granted twice consecutively while ch3 is pending.
- Flush: 2 entries in each channel, flush_i for 1 cycle with ch1 pushing → wb_valid_o=0 that cycle, all ch_ready_o=1 next cycle, no stale IDs ever written back.
- Reset priority: rst_i and flush_i asserted together mid-stream → all outputs 0 next cycle, the first push afterwards is granted from channel pointer 0.
